mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request from the EX stage, sampled at the rising edge.
REQ-006 SHALL have port op, input, 3, the operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port src_a, input, 32, rs operand, already forwarded.
REQ-008 SHALL have port src_b, input, 32, rt operand, already forwarded.
REQ-009 SHALL have port busy, output, 1, registered; high while a multiply or divide is in flight.
REQ-010 SHALL have port hi, output, 32, the architectural HI register (MFHI source).
REQ-011 SHALL have port lo, output, 32, the architectural LO register (MFLO source).

Function
REQ-012 SHALL accept start only when busy=0; start with busy=1 SHALL be ignored with no state change.
REQ-013 SHALL, on an accepted MULT (signed) or MULTU (unsigned), form the 64-bit product {HI,LO}=src_a*src_b.
REQ-014 SHALL, on an accepted DIV/DIVU, set LO=quotient and HI=remainder; signed quotient truncates toward zero, and the remainder takes the dividend's sign.
REQ-015 SHALL capture the result into internal pending registers at the accepting edge, so later operand changes have no effect.
REQ-016 SHALL load a down-counter with MULT_CYCLES or DIV_CYCLES at the accepting edge, set busy=1, and decrement the counter once per cycle.
REQ-017 SHALL write the pending result to hi/lo and clear busy at the edge where the counter reaches zero, so busy is high for exactly N cycles and hi/lo change on the same edge busy falls.
REQ-018 SHALL, when a new start is accepted on the edge where busy falls, see busy=0 at that edge only if busy has already cleared; no back-to-back overlap is allowed.
REQ-019 SHALL, on an accepted MTHI/MTLO, write src_a to hi/lo at the accepting edge, leave busy=0, and leave the other register unchanged.
REQ-020 SHALL, on DIV/DIVU with src_b=0, run the full DIV_CYCLES busy period and then leave hi and lo unchanged.
REQ-021 SHALL, on signed DIV of 0x80000000 by 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-022 SHALL treat op 6-7 with start=1 as a no-op: no busy and no register change.
REQ-023 SHALL keep the pending result and counter stable when start is deasserted mid-operation; no cancel input exists.
REQ-024 SHALL keep an FSM with states IDLE and RUN: IDLE->RUN on an accepted MULT/MULTU/DIV/DIVU; RUN->IDLE at counter zero; busy equals (state==RUN).

Reset
REQ-025 SHALL, on reset asserted, immediately force hi=0, lo=0, busy=0, state=IDLE, counter=0, and pending registers=0, independent of clk.
REQ-026 SHALL abort any in-flight operation on reset mid-operation, with no writeback after reset deasserts.
REQ-027 SHALL accept a new start on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place the op encodings (MDU_MULT..MDU_MTLO) and the default cycle constants in shared package mdu_pkg, which is also used by the hazard unit and the instruction decoder.
REQ-029 SHALL be a single module with no sub-module; the product and quotient use behavioral operators, and the latency is modelled by the counter.
REQ-030 SHALL be instantiated inside EX, with busy driving EX busy_out; the hazard unit stalls MFHI/MFLO/MULT/DIV in ID when busy or (EX start).

Verification
REQ-031 SHALL cover MULT: src_a=0xFFFFFFFF, src_b=2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 SHALL cover MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 SHALL cover DIV: src_a=-7, src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover divide by zero: hi=0x11, lo=0x22 preloaded via MTHI/MTLO, then DIVU by 0 -> busy 10 cycles, hi/lo still 0x11/0x22.
REQ-035 SHALL cover start during busy: a second MULT issued at cycle 2 of a DIV -> ignored, and only the DIV result is written at cycle 10.
REQ-036 SHALL cover reset mid-operation: reset asserted at cycle 3 of a MULT -> hi=lo=0 and busy=0 immediately, with no later writeback.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op encodings, default latencies, state type and divide helper
// Contents:
//   MDU_MULT..MDU_MTLO   3-bit op encodings (6-7 are no-ops)
//   MDU_MULT_CYCLES      default busy cycles for MULT/MULTU
//   MDU_DIV_CYCLES       default busy cycles for DIV/DIVU
//   mdu_state_t          IDLE/RUN state of the unit
//   mdu_divide()         {remainder, quotient} for signed or unsigned divide
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_RUN  = 1'b1
   } mdu_state_t;

   // Signed divide is done on magnitudes and the signs are reapplied, so the
   // 0x80000000 / -1 overflow case naturally yields quotient 0x80000000,
   // remainder 0 without relying on host signed-divide behaviour.
   function automatic logic [63:0] mdu_divide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
      logic        neg_a;
      logic        neg_b;
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] quot;
      logic [31:0] rem;
      neg_a = sgn & a[31];
      neg_b = sgn & b[31];
      mag_a = neg_a ? (~a + 32'd1) : a;
      mag_b = neg_b ? (~b + 32'd1) : b;
      quot  = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
      rem   = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
      if (neg_a ^ neg_b) quot = ~quot + 32'd1;
      if (neg_a)         rem  = ~rem + 32'd1;
      return {rem, quot};
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit with counter-modelled latency
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   start  in   1   one-cycle request, accepted only while not busy
//   op     in   3   MULT/MULTU/DIV/DIVU/MTHI/MTLO, 6-7 no-op
//   src_a  in  32   rs operand
//   src_b  in  32   rt operand
//   busy   out  1   high while a multiply or divide is in flight
//   hi     out 32   architectural HI
//   lo     out 32   architectural LO
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   mdu_state_t  state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [31:0] pend_hi, pend_hi_nxt;
   logic [31:0] pend_lo, pend_lo_nxt;
   logic        pend_wr, pend_wr_nxt;
   logic [31:0] hi_nxt, lo_nxt;

   logic        is_signed;
   logic [63:0] ext_a, ext_b, product, div_res;

   // Low 64 bits of a 64x64 product of extended operands give the exact
   // signed or unsigned 32x32 product.
   assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
   assign ext_a     = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
   assign ext_b     = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
   assign product   = ext_a * ext_b;
   assign div_res   = mdu_divide(src_a, src_b, is_signed);

   assign busy = (state == MDU_RUN);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_wr_nxt = pend_wr;
      hi_nxt      = hi;
      lo_nxt      = lo;
      case (state)
         MDU_IDLE: begin
            if (start) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     pend_hi_nxt = product[63:32];
                     pend_lo_nxt = product[31:0];
                     pend_wr_nxt = 1'b1;
                     cnt_nxt     = CW'(MULT_CYCLES);
                     state_nxt   = MDU_RUN;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     // Divide by zero still burns the full latency but never writes back.
                     pend_hi_nxt = div_res[63:32];
                     pend_lo_nxt = div_res[31:0];
                     pend_wr_nxt = (src_b != 32'd0);
                     cnt_nxt     = CW'(DIV_CYCLES);
                     state_nxt   = MDU_RUN;
                  end
                  MDU_MTHI: hi_nxt = src_a;
                  MDU_MTLO: lo_nxt = src_a;
                  default: ;
               endcase
            end
         end
         MDU_RUN: begin
            // Start is ignored here, including on the edge where busy falls.
            if (cnt <= CW'(1)) begin
               cnt_nxt   = '0;
               state_nxt = MDU_IDLE;
               if (pend_wr) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= MDU_IDLE;
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_wr <= pend_wr_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a one-cycle request at a negedge; operands are scrambled right
   // after the accepting edge so any late capture would show up.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
   endtask

   // Counts busy cycles sampled at negedges; also returns hi/lo seen on the
   // last busy cycle. Bounded so a stuck busy cannot hang the run.
   task automatic wait_done(output int n, output logic [31:0] last_hi, output logic [31:0] last_lo);
      n = 0;
      last_hi = hi;
      last_lo = lo;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         last_hi = hi;
         last_lo = lo;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      src_a = 32'd0;
      src_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int n; logic [31:0] lh, ll;
      issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
      wait_done(n, lh, ll);
      checks++;
      if (n !== 5) begin
         failures++;
         $display("FAIL mult_busy_cycles: got %0d required 5", n);
      end
      checks++;
      if (lh !== 32'd0 || ll !== 32'd0) begin
         failures++;
         $display("FAIL mult_early_write: hi=%h lo=%h during busy required 0/0", lh, ll);
      end
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffe", hi, lo);
      end
   endtask

   task automatic test_multu;
      int n; logic [31:0] lh, ll;
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_done(n, lh, ll);
      checks++;
      if (n !== 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL multu_result: cycles=%0d hi=%h lo=%h required 5 00000001/fffffffe", n, hi, lo);
      end
   endtask

   task automatic test_div;
      int n; logic [31:0] lh, ll;
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, lh, ll);
      checks++;
      if (n !== 10) begin
         failures++;
         $display("FAIL div_busy_cycles: got %0d required 10", n);
      end
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL div_result: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
      end
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n, lh, ll);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         failures++;
         $display("FAIL div_overflow: hi=%h lo=%h required 00000000/80000000", hi, lo);
      end
      issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
      wait_done(n, lh, ll);
      checks++;
      if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
         failures++;
         $display("FAIL divu_result: hi=%h lo=%h required 00000001/7ffffffc", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo_divzero;
      int n; logic [31:0] lh, ll;
      issue(MDU_MTHI, 32'h11, 32'h99);
      #1;
      checks++;
      if (hi !== 32'h11 || busy !== 1'b0 || lo !== 32'h7FFF_FFFC) begin
         failures++;
         $display("FAIL mthi: hi=%h lo=%h busy=%b required 00000011/7ffffffc busy=0", hi, lo, busy);
      end
      issue(MDU_MTLO, 32'h22, 32'h99);
      #1;
      checks++;
      if (lo !== 32'h22 || hi !== 32'h11 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b required 00000011/00000022 busy=0", hi, lo, busy);
      end
      issue(MDU_DIVU, 32'd1234, 32'd0);
      wait_done(n, lh, ll);
      checks++;
      if (n !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
         failures++;
         $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h required 10 00000011/00000022", n, hi, lo);
      end
   endtask

   task automatic test_nop;
      issue(3'd6, 32'hDEAD_BEEF, 32'h1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
         failures++;
         $display("FAIL nop_op6: busy=%b hi=%h lo=%h required 0 00000011/00000022", busy, hi, lo);
      end
   endtask

   task automatic test_start_during_busy;
      int n;
      issue(MDU_DIV, 32'd100, 32'd7);
      n = 0;
      @(negedge clk);
      if (busy) n++;
      start = 1'b1;
      op    = MDU_MULT;
      src_a = 32'd3;
      src_b = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      checks++;
      if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
         failures++;
         $display("FAIL start_during_busy: cycles=%0d hi=%h lo=%h required 10 00000002/0000000e", n, hi, lo);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
         failures++;
         $display("FAIL ignored_start_late: busy=%b hi=%h lo=%h required 0 00000002/0000000e", busy, hi, lo);
      end
   endtask

   task automatic test_back_to_back;
      int n; logic [31:0] lh, ll;
      // start held high: accepted, ignored on the falling-busy edge, re-accepted one edge later
      @(negedge clk);
      start = 1'b1;
      op    = MDU_MULTU;
      src_a = 32'd2;
      src_b = 32'd3;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      checks++;
      if (n !== 5 || busy !== 1'b0 || lo !== 32'd6 || hi !== 32'd0) begin
         failures++;
         $display("FAIL b2b_first: cycles=%0d busy=%b hi=%h lo=%h required 5 0 00000000/00000006", n, busy, hi, lo);
      end
      src_a = 32'd7;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_reaccept: busy=%b required 1", busy);
      end
      start = 1'b0;
      wait_done(n, lh, ll);
      checks++;
      if (n !== 4 || lo !== 32'd21 || hi !== 32'd0) begin
         failures++;
         $display("FAIL b2b_second: remaining=%0d hi=%h lo=%h required 4 00000000/00000015", n, hi, lo);
      end
   endtask

   task automatic test_reset_mid;
      issue(MDU_MTHI, 32'hAAAA_5555, 32'd0);
      issue(MDU_MULT, 32'd1000, 32'd1000);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_async: busy=%b hi=%h lo=%h required 0 0/0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_no_writeback: busy=%b hi=%h lo=%h required 0 0/0", busy, hi, lo);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1;
      op    = MDU_MTLO;
      src_a = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (lo !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL first_edge_after_reset: lo=%h required 0badf00d", lo);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_mthi_mtlo_divzero();
      test_nop();
      test_start_during_busy();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
